// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | switch_debouncer_pkg: shared constants and counter sizing helper  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package switch_debouncer_pkg;

  localparam int SW_WIDTH                = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

  // Smallest width w with 2**w > cycles, so the terminal count always fits.
  function automatic int min_cnt_w(input int cycles);
    int w;
    w = 31;
    for (int i = 31; i >= 1; i--) begin
      if ((longint'(1) << i) > longint'(cycles)) begin
        w = i;
      end
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debouncer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | switch_debouncer_if: raw switch input and conditioned outputs     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface switch_debouncer_if
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             any_change;
  logic             settled;

  modport master (
    input  sw_raw,
    output sw_out, sw_rise, sw_fall, any_change, settled
  );

  modport slave (
    output sw_raw,
    input  sw_out, sw_rise, sw_fall, any_change, settled
  );
endinterface
`default_nettype wire

// File: rtl/switch_debounce_bit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | switch_debounce_bit: 2-flop sync, stability counter, edge pulses  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module switch_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic sw_raw,
  output logic      sw_out,
  output logic      sw_rise,
  output logic      sw_fall,
  output logic      accept,
  output logic      match_next
);

  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_out_next;

  assign w_differ   = (r_sync2 != sw_out);
  assign accept     = w_differ && (r_cnt == C_TERM);
  assign w_out_next = accept ? r_sync2 : sw_out;
  // Next-state comparison lets the top register settled without an extra cycle of lag.
  assign match_next = (r_sync1 == w_out_next);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      sw_out  <= 1'b0;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
      if (!w_differ || accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      sw_out  <= w_out_next;
      sw_rise <= accept &  r_sync2;
      sw_fall <= accept & ~r_sync2;
    end
  end

endmodule
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | switch_debouncer: per-bit debounce array with change/settled flags|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = min_cnt_w(DEBOUNCE_CYCLES)
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  switch_debouncer_if.master sw_if
);

  generate
    if (DEBOUNCE_CYCLES < 2 ||
        (longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) begin : g_bad_params
      $error("switch_debouncer: illegal DEBOUNCE_CYCLES/CNT_W combination");
    end
  endgenerate

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_match_next;
  logic             r_any_change;
  logic             r_settled;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_bit (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_if.sw_raw[i]),
        .sw_out     (w_out[i]),
        .sw_rise    (w_rise[i]),
        .sw_fall    (w_fall[i]),
        .accept     (w_accept[i]),
        .match_next (w_match_next[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any_change <= 1'b0;
      r_settled    <= 1'b1;
    end else begin
      r_any_change <= |w_accept;
      r_settled    <= &w_match_next;
    end
  end

  assign sw_if.sw_out     = w_out;
  assign sw_if.sw_rise    = w_rise;
  assign sw_if.sw_fall    = w_fall;
  assign sw_if.any_change = r_any_change;
  assign sw_if.settled    = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_switch_debouncer: directed + random stimulus vs window model   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

  localparam int W  = SW_WIDTH;
  localparam int DC = DEBOUNCE_CYCLES_SIM;
  localparam int CW = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W)) sw_if ();

  switch_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_if   (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // hist[j] is the raw level sampled j clock edges ago.
  logic [W-1:0] hist [DC+2];
  logic [W-1:0] m_out, m_rise, m_fall;
  logic         m_any, m_settled;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic m_reset();
    for (int j = 0; j < DC + 2; j++) hist[j] = '0;
    m_out     = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_any     = 1'b0;
    m_settled = 1'b1;
  endtask

  // A bit flips when the DC raw samples that reach the counter (two sync
  // stages behind) all disagree with the current debounced level.
  task automatic m_step(input logic [W-1:0] raw);
    logic [W-1:0] nxt;
    logic         all_diff;
    for (int j = DC + 1; j >= 1; j--) hist[j] = hist[j-1];
    hist[0] = raw;
    nxt = m_out;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DC + 1; j++) begin
        if (hist[j][b] == m_out[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~m_out[b];
    end
    m_rise    = nxt & ~m_out;
    m_fall    = ~nxt & m_out;
    m_any     = |(m_rise | m_fall);
    m_out     = nxt;
    m_settled = (hist[1] == m_out);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) m_reset();
      else          m_step(sw_if.sw_raw);
      #1;
      check("sw_out",     32'(sw_if.sw_out),     32'(m_out));
      check("sw_rise",    32'(sw_if.sw_rise),    32'(m_rise));
      check("sw_fall",    32'(sw_if.sw_fall),    32'(m_fall));
      check("any_change", 32'(sw_if.any_change), 32'(m_any));
      check("settled",    32'(sw_if.settled),    32'(m_settled));
    end
  end

  initial begin
    logic [W-1:0] raw;
    sw_if.sw_raw = '0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Quiet inputs after reset
    repeat (20) @(negedge clk);
    check("idle_out",     32'(sw_if.sw_out),  32'h0);
    check("idle_settled", 32'(sw_if.settled), 32'h1);

    // Single-bit rise: visible on the sixth edge sampling the new level
    sw_if.sw_raw = 10'h001;
    repeat (5) @(negedge clk);
    check("s2_out_early", 32'(sw_if.sw_out),  32'h0);
    check("s2_unsettled", 32'(sw_if.settled), 32'h0);
    @(negedge clk);
    check("s2_out",     32'(sw_if.sw_out),     32'h001);
    check("s2_rise",    32'(sw_if.sw_rise),    32'h001);
    check("s2_any",     32'(sw_if.any_change), 32'h1);
    check("s2_settled", 32'(sw_if.settled),    32'h1);
    @(negedge clk);
    check("s2_rise_end", 32'(sw_if.sw_rise),    32'h0);
    check("s2_any_end",  32'(sw_if.any_change), 32'h0);

    // Glitch of 3 clocks on bit 3 is rejected
    sw_if.sw_raw = 10'h009;
    repeat (3) @(negedge clk);
    sw_if.sw_raw = 10'h001;
    repeat (10) @(negedge clk);
    check("s3_out",     32'(sw_if.sw_out),  32'h001);
    check("s3_settled", 32'(sw_if.settled), 32'h1);

    // Multi-bit simultaneous rise then fall
    sw_if.sw_raw = 10'h000;
    repeat (10) @(negedge clk);
    sw_if.sw_raw = 10'h2A5;
    repeat (5) @(negedge clk);
    check("s4_out_early", 32'(sw_if.sw_out), 32'h0);
    @(negedge clk);
    check("s4_out",  32'(sw_if.sw_out),     32'h2A5);
    check("s4_rise", 32'(sw_if.sw_rise),    32'h2A5);
    check("s4_any",  32'(sw_if.any_change), 32'h1);
    @(negedge clk);
    check("s4_any_end", 32'(sw_if.any_change), 32'h0);
    sw_if.sw_raw = 10'h000;
    repeat (6) @(negedge clk);
    check("s4_fall",     32'(sw_if.sw_fall), 32'h2A5);
    check("s4_out_fall", 32'(sw_if.sw_out),  32'h0);

    // Switches high through reset release
    reset_n      = 1'b0;
    sw_if.sw_raw = 10'h3FF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("s5_out_early", 32'(sw_if.sw_out), 32'h0);
    @(negedge clk);
    check("s5_out",  32'(sw_if.sw_out),  32'h3FF);
    check("s5_rise", 32'(sw_if.sw_rise), 32'h3FF);

    // Reset in the middle of bit 5's count
    sw_if.sw_raw = 10'h000;
    repeat (10) @(negedge clk);
    sw_if.sw_raw = 10'h020;
    repeat (4) @(negedge clk);
    check("s6_unsettled", 32'(sw_if.settled), 32'h0);
    reset_n = 1'b0;
    #1;
    check("s6_rst_settled", 32'(sw_if.settled),    32'h1);
    check("s6_rst_out",     32'(sw_if.sw_out),     32'h0);
    check("s6_rst_any",     32'(sw_if.any_change), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("s6_out_early", 32'(sw_if.sw_out), 32'h0);
    @(negedge clk);
    check("s6_out", 32'(sw_if.sw_out), 32'h020);

    // Random bursts with hold times straddling the debounce threshold
    raw = sw_if.sw_raw;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) raw = raw ^ W'($urandom_range(0, 1023));
      else                           raw = raw ^ (W'(1) << $urandom_range(0, W - 1));
      sw_if.sw_raw = raw;
      repeat ($urandom_range(1, 8)) @(negedge clk);
      if (n % 97 == 50) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
